// File: rtl/multicycle_arm.sv
// rtl/multicycle_arm.sv - multicycle ARMv8-subset core on a unified memory port
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   mem_addr          byte address (pc during fetch, effective address during MEM)
//   mem_wdata         store data (Rt value of the current instruction)
//   mem_rd / mem_wr   read / write request, held until mem_ready
//   mem_rdata         read data; instructions occupy bits [31:0]
//   mem_ready         completes the current request in the cycle it is high
//   pc                current program counter
//   halted, illegal   core stopped; illegal marks an undecodable instruction
//   instret           retired-instruction count, wraps at 2^32
module multicycle_arm #(
    parameter int                DATA_W   = 64,
    parameter int                REG_NUM  = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] pc,
    output logic              halted,
    output logic              illegal,
    output logic [31:0]       instret
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR,
        OP_CBZ, OP_B, OP_HLT, OP_ILL
    } op_t;

    state_t            state;
    op_t               op;
    op_t               dec_op;
    logic [31:0]       ir;
    logic [DATA_W-1:0] regs [REG_NUM];
    logic [DATA_W-1:0] val_n, val_m, val_t;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] dec_imm;
    logic [DATA_W-1:0] res;

    // X31 and unimplemented indices read as zero.
    function automatic logic [DATA_W-1:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd31 || int'(idx) >= REG_NUM)
            return '0;
        return regs[idx];
    endfunction

    function automatic logic reg_writable(input logic [4:0] idx);
        return (idx != 5'd31) && (int'(idx) < REG_NUM);
    endfunction

    always_comb begin
        dec_op = OP_ILL;
        if (ir == 32'hD440_0000)
            dec_op = OP_HLT;
        else if (ir[31:26] == 6'b000101)
            dec_op = OP_B;
        else if (ir[31:24] == 8'b1011_0100)
            dec_op = OP_CBZ;
        else begin
            case (ir[31:21])
                11'b10001011000: dec_op = OP_ADD;
                11'b11001011000: dec_op = OP_SUB;
                11'b10001010000: dec_op = OP_AND;
                11'b10101010000: dec_op = OP_ORR;
                11'b11111000010: dec_op = OP_LDUR;
                11'b11111000000: dec_op = OP_STUR;
                default:         dec_op = OP_ILL;
            endcase
        end
    end

    // Branch offsets are pre-scaled to bytes so EXECUTE only adds.
    always_comb begin
        dec_imm = {{(DATA_W-9){ir[20]}}, ir[20:12]};
        if (dec_op == OP_CBZ)
            dec_imm = {{(DATA_W-21){ir[23]}}, ir[23:5], 2'b00};
        else if (dec_op == OP_B)
            dec_imm = {{(DATA_W-28){ir[25]}}, ir[25:0], 2'b00};
    end

    // Requests are decoded from state so a fetch can start in the very first
    // cycle after reset; gating with reset keeps them low while reset is held.
    always_comb begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        if (!reset) begin
            mem_rd = (state == S_FETCH) || (state == S_MEM && op == OP_LDUR);
            mem_wr = (state == S_MEM && op == OP_STUR);
        end
    end

    assign mem_addr  = (state == S_FETCH) ? pc : res;
    assign mem_wdata = val_t;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            op      <= OP_ILL;
            ir      <= '0;
            val_n   <= '0;
            val_m   <= '0;
            val_t   <= '0;
            imm     <= '0;
            res     <= '0;
            pc      <= RESET_PC;
            halted  <= 1'b0;
            illegal <= 1'b0;
            instret <= '0;
            for (int i = 0; i < REG_NUM; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata[31:0];
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op    <= dec_op;
                    imm   <= dec_imm;
                    val_n <= read_reg(ir[9:5]);
                    val_m <= read_reg(ir[20:16]);
                    val_t <= read_reg(ir[4:0]);
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (op)
                        OP_ADD: begin res <= val_n + val_m; state <= S_WB; end
                        OP_SUB: begin res <= val_n - val_m; state <= S_WB; end
                        OP_AND: begin res <= val_n & val_m; state <= S_WB; end
                        OP_ORR: begin res <= val_n | val_m; state <= S_WB; end
                        OP_LDUR, OP_STUR: begin
                            res   <= val_n + imm;
                            state <= S_MEM;
                        end
                        OP_CBZ: begin
                            pc      <= (val_t == '0) ? pc + imm : pc + DATA_W'(4);
                            instret <= instret + 32'd1;
                            state   <= S_FETCH;
                        end
                        OP_B: begin
                            pc      <= pc + imm;
                            instret <= instret + 32'd1;
                            state   <= S_FETCH;
                        end
                        OP_HLT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                            state   <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op == OP_LDUR) begin
                            res   <= mem_rdata;
                            state <= S_WB;
                        end else begin
                            pc      <= pc + DATA_W'(4);
                            instret <= instret + 32'd1;
                            state   <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    // Rt for loads and Rd for R-type share bits [4:0].
                    if (reg_writable(ir[4:0]))
                        regs[ir[4:0]] <= res;
                    pc      <= pc + DATA_W'(4);
                    instret <= instret + 32'd1;
                    state   <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_arm.sv
// tb/tb_multicycle_arm.sv - directed self-checking bench for multicycle_arm
module tb_multicycle_arm;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        mem_rd, mem_wr, halted, illegal;
    logic        mem_ready = 1'b1;
    logic [31:0] instret;

    logic [63:0] mem [256];
    logic [63:0] wr_addr [$];
    logic [63:0] wr_data [$];

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_arm dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .halted    (halted),
        .illegal   (illegal),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_wr && mem_ready) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] enc_r(input logic [10:0] opc, input logic [4:0] rm,
                                         input logic [4:0] rn, input logic [4:0] rd);
        return {opc, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] enc_d(input logic [10:0] opc, input logic [8:0] imm9,
                                         input logic [4:0] rn, input logic [4:0] rt);
        return {opc, imm9, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] enc_cbz(input logic [18:0] imm19, input logic [4:0] rt);
        return {8'b1011_0100, imm19, rt};
    endfunction

    function automatic logic [31:0] enc_b(input logic [25:0] imm26);
        return {6'b000101, imm26};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++)
            mem[i] = '0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    function automatic logic [63:0] wr_at(input int i, input logic want_data);
        if (i >= wr_addr.size())
            return '1;
        return want_data ? wr_data[i] : wr_addr[i];
    endfunction

    initial begin
        // Load/add/store program, mem[16]=5, mem[24]=7.
        clear_mem();
        mem[0] = 64'(enc_d(OPC_LDUR, 9'd16, 5'd31, 5'd1));
        mem[1] = 64'(enc_d(OPC_LDUR, 9'd24, 5'd31, 5'd2));
        mem[2] = 64'(enc_r(OPC_ADD, 5'd2, 5'd1, 5'd3));
        mem[3] = 64'(enc_d(OPC_STUR, 9'd32, 5'd31, 5'd3));
        mem[4] = 64'd5;
        mem[6] = 64'd7;
        reset = 1'b1;
        step(2);
        check("rst_pc", pc, 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_instret", 64'(instret), 64'd0);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        reset = 1'b0;
        #1;
        check("first_fetch_rd", 64'(mem_rd), 64'd1);
        check("first_fetch_addr", mem_addr, 64'd0);
        step(17);
        check("prog_instret_17", 64'(instret), 64'd3);
        step(1);
        check("prog_instret_18", 64'(instret), 64'd4);
        check("prog_pc_18", pc, 64'd16);
        check("prog_wr_count", 64'(wr_addr.size()), 64'd1);
        check("prog_wr_addr", wr_at(0, 1'b0), 64'd32);
        check("prog_wr_data", wr_at(0, 1'b1), 64'd12);
        // Data word 5 at pc=16 is not a valid instruction.
        step(3);
        check("data_as_insn_halted", 64'(halted), 64'd1);
        check("data_as_insn_illegal", 64'(illegal), 64'd1);
        check("data_as_insn_pc", pc, 64'd16);

        // Fetch stall, then illegal 0xFFFFFFFF.
        clear_mem();
        mem[0] = 64'h0000_0000_FFFF_FFFF;
        mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("stall_mem_rd", 64'(mem_rd), 64'd1);
            check("stall_mem_addr", mem_addr, 64'd0);
            check("stall_instret", 64'(instret), 64'd0);
        end
        mem_ready = 1'b1;
        step(3);
        check("ill_halted", 64'(halted), 64'd1);
        check("ill_illegal", 64'(illegal), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("ill_no_req", 64'({mem_rd, mem_wr}), 64'd0);
            check("ill_pc_held", pc, 64'd0);
        end
        check("ill_instret", 64'(instret), 64'd0);

        // B forward, CBZ taken on X31, B backward with negative offset.
        clear_mem();
        mem[0] = 64'(enc_b(26'd2));
        mem[2] = 64'(enc_cbz(19'd3, 5'd31));
        mem[5] = 64'(enc_b(26'h3FF_FFFB));
        do_reset();
        step(3);
        check("b_fwd_pc", pc, 64'h8);
        step(3);
        check("cbz_taken_pc", pc, 64'h14);
        check("cbz_taken_instret", 64'(instret), 64'd2);
        step(3);
        check("b_back_pc", pc, 64'h0);
        check("b_back_instret", 64'(instret), 64'd3);

        // CBZ not taken, X31 sink, ALU ops, negative store offset, HLT.
        clear_mem();
        mem[0]  = 64'(enc_d(OPC_LDUR, 9'd64, 5'd31, 5'd1));
        mem[1]  = 64'(enc_d(OPC_LDUR, 9'd72, 5'd31, 5'd2));
        mem[2]  = 64'(enc_cbz(19'd3, 5'd1));
        mem[3]  = 64'(enc_r(OPC_ADD, 5'd1, 5'd1, 5'd31));
        mem[4]  = 64'(enc_d(OPC_STUR, 9'd80, 5'd31, 5'd31));
        mem[5]  = 64'(enc_r(OPC_SUB, 5'd1, 5'd2, 5'd4));
        mem[6]  = 64'(enc_r(OPC_AND, 5'd2, 5'd1, 5'd5));
        mem[7]  = 64'(enc_r(OPC_ORR, 5'd2, 5'd1, 5'd6));
        mem[8]  = 64'(enc_r(OPC_SUB, 5'd2, 5'd1, 5'd7));
        mem[9]  = 64'(enc_d(OPC_STUR, 9'd88, 5'd31, 5'd4));
        mem[10] = 64'(enc_d(OPC_STUR, 9'd96, 5'd31, 5'd5));
        mem[11] = 64'(enc_d(OPC_STUR, 9'd104, 5'd31, 5'd6));
        mem[12] = 64'(enc_d(OPC_STUR, 9'h1FC, 5'd2, 5'd7));
        mem[13] = 64'h0000_0000_D440_0000;
        mem[16] = 64'd9;
        mem[18] = 64'd12;
        do_reset();
        step(13);
        check("cbz_not_taken_pc", pc, 64'hC);
        check("cbz_not_taken_instret", 64'(instret), 64'd3);
        step(43);
        check("hlt_halted", 64'(halted), 64'd1);
        check("hlt_illegal", 64'(illegal), 64'd0);
        check("hlt_pc", pc, 64'h34);
        check("hlt_instret", 64'(instret), 64'd13);
        check("alu_wr_count", 64'(wr_addr.size()), 64'd5);
        check("x31_st_addr", wr_at(0, 1'b0), 64'd80);
        check("x31_st_data", wr_at(0, 1'b1), 64'd0);
        check("sub_st_data", wr_at(1, 1'b1), 64'd3);
        check("and_st_data", wr_at(2, 1'b1), 64'd8);
        check("orr_st_data", wr_at(3, 1'b1), 64'd13);
        check("neg_off_addr", wr_at(4, 1'b0), 64'd8);
        check("sub_wrap_data", wr_at(4, 1'b1), 64'hFFFF_FFFF_FFFF_FFFD);
        step(2);
        check("hlt_no_req", 64'({mem_rd, mem_wr}), 64'd0);
        check("hlt_pc_held", pc, 64'h34);

        // Reset during a stalled STUR.
        clear_mem();
        mem[0] = 64'(enc_b(26'd1));
        mem[1] = 64'(enc_d(OPC_STUR, 9'd80, 5'd31, 5'd31));
        do_reset();
        step(6);
        mem_ready = 1'b0;
        check("stur_stall_wr", 64'(mem_wr), 64'd1);
        check("stur_stall_addr", mem_addr, 64'd80);
        check("stur_stall_instret", 64'(instret), 64'd1);
        step(2);
        check("stur_stall_wr_held", 64'(mem_wr), 64'd1);
        check("stur_stall_pc", pc, 64'd4);
        reset = 1'b1;
        step(1);
        check("rst_stall_wr", 64'(mem_wr), 64'd0);
        check("rst_stall_pc", pc, 64'd0);
        check("rst_stall_instret", 64'(instret), 64'd0);
        check("rst_stall_no_write", 64'(wr_addr.size()), 64'd0);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("restart_rd", 64'(mem_rd), 64'd1);
        check("restart_addr", mem_addr, 64'd0);
        step(3);
        check("restart_b_pc", pc, 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_arm.md
MULTICYCLE_ARM -- requirements
Module: multicycle_arm

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 64, meaning datapath, register and address width.
REQ-002 The block SHALL provide parameter REG_NUM, default 32, meaning the number of implemented registers (2..32).
REQ-003 The block SHALL provide parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_addr  output  DATA_W  byte address for the unified instruction/data port.
REQ-007 mem_wdata  output  DATA_W  store data.
REQ-008 mem_rd  output  1  read request.
REQ-009 mem_wr  output  1  write request; never high together with mem_rd.
REQ-010 mem_rdata  input  DATA_W  read data; an instruction occupies bits [31:0].
REQ-011 mem_ready  input  1  completes the current request in the cycle it is sampled high.
REQ-012 pc  output  DATA_W  current program counter.
REQ-013 halted  output  1  core stopped.
REQ-014 illegal  output  1  the stop was caused by an undecodable instruction.
REQ-015 instret  output  32  count of retired instructions; wraps at 2^32.

Function
REQ-016 The FSM SHALL have states FETCH, DECODE, EXECUTE, MEM, WB and HALT.
REQ-017 FETCH SHALL drive mem_rd=1 and mem_addr=pc, holding both until mem_ready=1, then latch mem_rdata[31:0] and go to DECODE.
REQ-018 DECODE SHALL take 1 cycle: read Rn=[9:5], Rm=[20:16], Rt=[4:0], and sign-extend the immediate.
REQ-019 Decoding SHALL be: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ [31:24]=10110100, B [31:26]=000101, HLT 32'hD4400000; any other encoding SHALL be illegal.
REQ-020 EXECUTE SHALL take 1 cycle. R-type results go to WB. LDUR/STUR compute address Rn+sext(imm9 [20:12]) and go to MEM. Illegal goes to HALT with illegal=1. HLT goes to HALT with illegal=0.
REQ-021 CBZ SHALL set pc=pc+(sext(imm19 [23:5])<<2) when Rt==0, otherwise pc+4; B SHALL set pc=pc+(sext(imm26)<<2); both retire in EXECUTE and return to FETCH.
REQ-022 MEM SHALL assert mem_rd (LDUR) or mem_wr with mem_wdata=Rt (STUR), held stable until mem_ready. STUR then retires to FETCH; LDUR latches mem_rdata and goes to WB.
REQ-023 WB SHALL write Rt (loads) or Rd (R-type), set pc=pc+4, and return to FETCH.
REQ-024 Register 31 SHALL read as zero and ignore writes; indices >= REG_NUM SHALL behave the same way.
REQ-025 All arithmetic SHALL be DATA_W-bit modulo; PC addition SHALL wrap silently.
REQ-026 instret SHALL increment by 1 exactly in the retire cycle of each non-HLT, non-illegal instruction.
REQ-027 Latency with mem_ready constantly 1 SHALL be: R-type 4 cycles, LDUR 5, STUR 4, CBZ/B 3.
REQ-028 In HALT, the block SHALL keep mem_rd=mem_wr=0, hold pc and registers frozen, and stay there until reset.
REQ-029 mem_addr and mem_wdata SHALL be don't-care while mem_rd=mem_wr=0.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL set: pc=RESET_PC; all registers=0; state=FETCH; halted=0; illegal=0; instret=0; mem_rd=mem_wr=0.
REQ-031 Reset SHALL take priority in every state, including a stalled MEM or FETCH. The pending request SHALL drop in the cycle after the reset edge, with no register or pc update.
REQ-032 FETCH of RESET_PC SHALL begin in the first cycle after reset deasserts.

Verification
REQ-033 Program at RESET_PC=0: LDUR X1,[X31,#16]; LDUR X2,[X31,#24]; ADD X3,X1,X2; STUR X3,[X31,#32], with mem[16]=5, mem[24]=7 -> write of 12 at address 32, instret=4 after 18 cycles.
REQ-034 mem_ready low for 3 cycles during FETCH -> mem_rd stays 1, mem_addr constant, no state advance, instret unchanged.
REQ-035 CBZ X31 with imm19=3 at pc=0x8 -> pc=0x14 after 3 cycles; CBZ on nonzero Rt -> pc=0xC.
REQ-036 ADD X31,X1,X1 followed by STUR X31 -> stored value 0.
REQ-037 Instruction 32'hFFFFFFFF -> halted=1, illegal=1, pc held, no further mem_rd/mem_wr; 32'hD4400000 -> halted=1, illegal=0.
REQ-038 Reset pulsed during a STUR stall (mem_ready=0) -> mem_wr=0 next cycle, pc=RESET_PC, instret=0, fetch restarts.
